vec_lsu_seq: RTL and testbench

//  Multi-beat scalar/vector load-store sequencer for the vector CPU execute stage.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_addr_gen.sv | 52 +++++
 rtl/vec_lsu_seq.sv | 141 ++++++++++++++
 tb/tb_vec_lsu_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the vector load/store sequencer: operation codes,
// sequencer states and the beat-count helper.
package lsu_pkg;

    // Bit 0 selects store, bit 1 selects vector width.
    typedef enum logic [1:0] {
        LD_ESC = 2'd0,
        ST_ESC = 2'd1,
        LD_VEC = 2'd2,
        ST_VEC = 2'd3
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } lsu_state_t;

    // Number of bus beats an operation needs: scalars always take one.
    function automatic int unsigned lsu_beats(input lsu_op_t op, input int unsigned vec_beats);
        return op[1] ? vec_beats : 32'd1;
    endfunction

    function automatic logic lsu_is_store(input lsu_op_t op);
        return op[0];
    endfunction

    function automatic logic lsu_is_vec(input lsu_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/lsu_addr_gen.sv
// Beat address generator: loads the base address when an op is accepted and
// advances by one step on every acknowledged beat. Arithmetic wraps modulo
// 2^ADDR_W. With VEC_LSU_STRIDE_EN defined the step is the latched signed
// stride; otherwise it is the fixed bus width in bytes and stride is ignored.
module lsu_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] inc;

`ifdef VEC_LSU_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;

    // Capture the per-op stride alongside the base address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stride_q <= '0;
        end else if (load) begin
            stride_q <= stride;
        end
    end

    // Two's-complement add handles negative strides without sign logic.
    assign inc = stride_q;
`else
    logic stride_unused;

    assign stride_unused = ^stride;
    assign inc           = ADDR_W'(STEP);
`endif

    // Beat address register: base on load, step on each accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
        end else if (load) begin
            addr <= base;
        end else if (step) begin
            addr <= addr + inc;
        end
    end

endmodule

// File: rtl/vec_lsu_seq.sv
// Multi-beat scalar/vector load-store sequencer. Moves one BUS_W scalar or one
// LANES*LANE_W vector across a BUS_W memory port using a req/ack handshake,
// and reports completion with a one-cycle done pulse.
// Optional feature macro: VEC_LSU_STRIDE_EN (signed stride between vector beats).
module vec_lsu_seq
    import lsu_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int LANE_W = 8,
    parameter int BUS_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  lsu_op_t                 op,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       stride,
    input  logic [BUS_W-1:0]        esc_wdata,
    input  logic [LANES*LANE_W-1:0] vec_wdata,
    input  logic                    mem_ack,
    input  logic [BUS_W-1:0]        mem_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [BUS_W-1:0]        mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic [BUS_W-1:0]        esc_rdata,
    output logic [LANES*LANE_W-1:0] vec_rdata
);

    localparam int VEC_W = LANES * LANE_W;
    localparam int BEATS = VEC_W / BUS_W;
    localparam int CNT_W = $clog2(BEATS + 1);

    if ((VEC_W % BUS_W) != 0) begin : g_bad_vec_w
        $error("vec_lsu_seq: VEC_W must be a multiple of BUS_W");
    end
    if ((BUS_W % 8) != 0) begin : g_bad_bus_w
        $error("vec_lsu_seq: BUS_W must be a whole number of bytes");
    end

    lsu_state_t        state_q;
    lsu_state_t        state_d;
    lsu_op_t           op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [VEC_W-1:0]  wdata_q;
    logic [VEC_W-1:0]  shadow_q;
    logic [VEC_W-1:0]  shadow_next;
    logic [ADDR_W-1:0] beat_addr;
    logic              issue;
    logic              accept;
    logic              beat_done;
    logic              last_beat;

    assign issue     = (state_q == ISSUE);
    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
    assign beat_done = issue && mem_ack;
    assign last_beat = (32'(cnt_q) == (lsu_beats(op_q, 32'(BEATS)) - 32'd1));

    // Read beats enter at the top and shift down, so beat 0 ends at the LSBs.
    assign shadow_next = (shadow_q >> BUS_W) | (VEC_W'(mem_rdata) << (VEC_W - BUS_W));

    // State register.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking assignments here would chain updates within one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start while in ISSUE is deliberately not queued.
    // NOTE: state_d is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (mem_ack && last_beat) state_d = DONE;
            DONE:    state_d = start ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Op latch, beat counter, write-data shifter, read shadow and results.
    // NOTE: the shadow and result vectors are reset too, so an op abandoned by
    // reset can never expose stale or partial load data afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= LD_ESC;
            cnt_q     <= '0;
            wdata_q   <= '0;
            shadow_q  <= '0;
            esc_rdata <= '0;
            vec_rdata <= '0;
        end else if (accept) begin
            op_q    <= op;
            cnt_q   <= '0;
            wdata_q <= lsu_is_vec(op) ? vec_wdata : VEC_W'(esc_wdata);
        end else if (beat_done) begin
            cnt_q   <= cnt_q + CNT_W'(1);
            wdata_q <= wdata_q >> BUS_W;
            if (!lsu_is_store(op_q)) begin
                shadow_q <= shadow_next;
                if (last_beat) begin
                    if (lsu_is_vec(op_q)) begin
                        vec_rdata <= shadow_next;
                    end else begin
                        esc_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    lsu_addr_gen #(
        .ADDR_W (ADDR_W),
        .STEP   (BUS_W / 8)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (beat_done),
        .base   (base_addr),
        .stride (stride),
        .addr   (beat_addr)
    );

    // Memory-side outputs are driven only while a beat is being issued.
    assign mem_req   = issue;
    assign mem_we    = issue && lsu_is_store(op_q);
    assign mem_addr  = issue ? beat_addr : '0;
    assign mem_wdata = issue ? wdata_q[BUS_W-1:0] : '0;
    assign busy      = issue;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_vec_lsu_seq.sv
// Directed scoreboard bench for vec_lsu_seq (default parameters, two beats
// per vector). Inputs change on the falling edge; outputs are sampled there.
module tb_vec_lsu_seq;
    import lsu_pkg::*;

    localparam int BUS_W  = 32;
    localparam int VEC_W  = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = VEC_W / BUS_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    lsu_op_t           op = LD_ESC;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] stride = '0;
    logic [BUS_W-1:0]  esc_wdata = '0;
    logic [VEC_W-1:0]  vec_wdata = '0;
    logic              mem_ack = 1'b0;
    logic [BUS_W-1:0]  mem_rdata = '0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BUS_W-1:0]  mem_wdata;
    logic              busy;
    logic              done;
    logic [BUS_W-1:0]  esc_rdata;
    logic [VEC_W-1:0]  vec_rdata;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BUS_W-1:0]  wdata;
        logic [BUS_W-1:0]  rdata;
    } beat_t;

    beat_t            sb[$];
    int               n_checks = 0;
    int               n_errors = 0;
    logic [VEC_W-1:0] exp_vec = '0;
    logic [BUS_W-1:0] exp_esc = '0;

    vec_lsu_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .base_addr (base_addr),
        .stride    (stride),
        .esc_wdata (esc_wdata),
        .vec_wdata (vec_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .esc_rdata (esc_rdata),
        .vec_rdata (vec_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference beat address.
    function automatic logic [ADDR_W-1:0] model_addr(input lsu_op_t o, input logic [ADDR_W-1:0] b,
                                                     input logic [ADDR_W-1:0] s, input int k);
        if (!o[1]) return b;
`ifdef VEC_LSU_STRIDE_EN
        return b + ADDR_W'(k) * s;
`else
        return b + ADDR_W'(k * (BUS_W / 8));
`endif
    endfunction

    // Called at a falling edge: pushes the expected beats, drives start for one
    // rising edge, and returns at the falling edge of the first ISSUE cycle.
    task automatic start_op(input lsu_op_t o, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                            input logic [VEC_W-1:0] vw, input logic [BUS_W-1:0] ew,
                            input logic [VEC_W-1:0] rd);
        int    nb;
        beat_t bt;
        nb = o[1] ? BEATS : 1;
        for (int k = 0; k < nb; k++) begin
            bt.addr  = model_addr(o, b, s, k);
            bt.we    = o[0];
            bt.wdata = o[1] ? vw[k*BUS_W +: BUS_W] : ew;
            bt.rdata = rd[k*BUS_W +: BUS_W];
            sb.push_back(bt);
        end
        start     = 1'b1;
        op        = o;
        base_addr = b;
        stride    = s;
        vec_wdata = vw;
        esc_wdata = ew;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    // Serves every beat with wait_n stall cycles, checks each request against
    // the scoreboard, then checks the done cycle. Optionally holds start high
    // with a different op during ISSUE, which must be ignored.
    task automatic run_beats(input lsu_op_t o, input logic [VEC_W-1:0] rd, input int wait_n,
                             input bit poke_start);
        int    nb;
        beat_t bt;
        nb = o[1] ? BEATS : 1;
        for (int k = 0; k < nb; k++) begin
            for (int w = 0; w <= wait_n; w++) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    bt = sb[0];
                    check("mem_req", 64'(mem_req), 64'd1);
                    check("mem_addr", 64'(mem_addr), 64'(bt.addr));
                    check("mem_we", 64'(mem_we), 64'(bt.we));
                    if (bt.we) check("mem_wdata", 64'(mem_wdata), 64'(bt.wdata));
                    check("busy_issue", 64'(busy), 64'd1);
                    check("done_issue", 64'(done), 64'd0);
                    check("vec_rdata_hold", vec_rdata, exp_vec);
                    check("esc_rdata_hold", 64'(esc_rdata), 64'(exp_esc));
                    if (poke_start) begin
                        start     = 1'b1;
                        op        = ST_ESC;
                        base_addr = 32'hDEAD_0000;
                    end
                    if (w == wait_n) begin
                        mem_ack   = 1'b1;
                        mem_rdata = bt.rdata;
                        void'(sb.pop_front());
                    end
                end
                @(posedge clk);
                #1 mem_ack = 1'b0;
                mem_rdata = '0;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!o[0]) begin
            if (o[1]) exp_vec = rd;
            else      exp_esc = rd[BUS_W-1:0];
        end
        check("done_pulse", 64'(done), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        check("req_done", 64'(mem_req), 64'd0);
        check("vec_rdata_result", vec_rdata, exp_vec);
        check("esc_rdata_result", 64'(esc_rdata), 64'(exp_esc));
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Advance from the done cycle to the following one and confirm return to idle.
    task automatic expect_idle();
        @(posedge clk);
        @(negedge clk);
        check("done_cleared", 64'(done), 64'd0);
        check("req_idle", 64'(mem_req), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        // Reset state.
        #12;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_esc_rdata", 64'(esc_rdata), 64'd0);
        check("rst_vec_rdata", vec_rdata, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1: vector load, zero-wait memory.
        start_op(LD_VEC, 32'h100, 32'd4, '0, '0, 64'h22222222_11111111);
        run_beats(LD_VEC, 64'h22222222_11111111, 0, 1'b0);
        expect_idle();

        // 2: vector store with two stall cycles per beat.
        start_op(ST_VEC, 32'h300, 32'd4, 64'hAABBCCDD_01020304, '0, '0);
        run_beats(ST_VEC, '0, 2, 1'b0);
        expect_idle();

        // 3: scalar load at the top of memory, then a vector load that wraps.
        start_op(LD_ESC, 32'hFFFF_FFFC, 32'd4, '0, '0, 64'h0000_0000_5A5A_A5A5);
        run_beats(LD_ESC, 64'h0000_0000_5A5A_A5A5, 0, 1'b0);
        expect_idle();
        start_op(LD_VEC, 32'hFFFF_FFFC, 32'd4, '0, '0, 64'hCAFEF00D_BEEF0001);
        run_beats(LD_VEC, 64'hCAFEF00D_BEEF0001, 1, 1'b0);
        expect_idle();

        // 4: back-to-back start from DONE, then start held during ISSUE.
        start_op(ST_ESC, 32'h40, 32'd4, '0, 32'h1234_5678, '0);
        run_beats(ST_ESC, '0, 0, 1'b0);
        start_op(LD_VEC, 32'h80, 32'd4, '0, '0, 64'h0F0F0F0F_F0F0F0F0);
        run_beats(LD_VEC, 64'h0F0F0F0F_F0F0F0F0, 0, 1'b1);
        expect_idle();
        check("sb_after_ignored_start", 64'(sb.size()), 64'd0);

        // 5: reset after the first beat of a vector load.
        start_op(LD_VEC, 32'h500, 32'd4, '0, '0, 64'h99999999_88888888);
        check("abort_mem_addr", 64'(mem_addr), 64'h500);
        mem_ack   = 1'b1;
        mem_rdata = 32'h8888_8888;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("abort_mem_req", 64'(mem_req), 64'd0);
        check("abort_mem_addr_zero", 64'(mem_addr), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_vec_rdata", vec_rdata, 64'd0);
        check("abort_esc_rdata", 64'(esc_rdata), 64'd0);
        sb.delete();
        exp_vec = '0;
        exp_esc = '0;
        @(negedge clk);
        check("abort_hold_vec", vec_rdata, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        start_op(LD_VEC, 32'h600, 32'd4, '0, '0, 64'h76543210_FEDCBA98);
        run_beats(LD_VEC, 64'h76543210_FEDCBA98, 0, 1'b0);
        expect_idle();

        // 6: negative stride (honoured only when the stride feature is built in).
        start_op(LD_VEC, 32'h200, 32'hFFFF_FFC0, '0, '0, 64'h44444444_33333333);
        run_beats(LD_VEC, 64'h44444444_33333333, 0, 1'b0);
        expect_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
